// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - four-entry unified reservation station with CDB wakeup
//
// Purpose: holds up to four dispatched instructions until both source operands
// are available, then presents them to the functional-unit scheduler.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush                 squash all entries
//   disp_*                dispatch request, operand capture inputs; disp_ready out
//   cdb_valid/tag/value   common data bus result broadcast
//   consumed_bus          one-hot entry free from the scheduler
//   rs0_data..rs3_data    per-entry rs_out_t record (entry 0 has highest priority)

package reservation_station_pkg;
    typedef struct packed {
        logic        valid_operands;
        logic [2:0]  ALU_op;
        logic [3:0]  ROB_entry;
        logic [1:0]  branch_type;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } rs_out_t;
endpackage

module reservation_station
    import reservation_station_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        disp_valid,
    output logic        disp_ready,
    input  logic [2:0]  disp_ALU_op,
    input  logic [1:0]  disp_branch_type,
    input  logic [3:0]  disp_ROB_entry,
    input  logic        disp_src1_rdy,
    input  logic        disp_src2_rdy,
    input  logic [3:0]  disp_src1_tag,
    input  logic [3:0]  disp_src2_tag,
    input  logic [31:0] disp_src1_val,
    input  logic [31:0] disp_src2_val,
    input  logic        cdb_valid,
    input  logic [3:0]  cdb_tag,
    input  logic [31:0] cdb_value,
    input  logic [3:0]  consumed_bus,
    output rs_out_t     rs0_data,
    output rs_out_t     rs1_data,
    output rs_out_t     rs2_data,
    output rs_out_t     rs3_data
);

    logic [3:0]  busy;
    logic [2:0]  op_q    [4];
    logic [1:0]  btype_q [4];
    logic [3:0]  rob_q   [4];
    logic [3:0]  s1_rdy;
    logic [3:0]  s2_rdy;
    logic [3:0]  s1_tag  [4];
    logic [3:0]  s2_tag  [4];
    logic [31:0] s1_val  [4];
    logic [31:0] s2_val  [4];

    logic [1:0]  alloc_idx;
    logic        accept;
    logic        cap1_rdy;
    logic        cap2_rdy;
    logic [31:0] cap1_val;
    logic [31:0] cap2_val;
    rs_out_t     outs [4];

    // Lowest free entry, judged on registered busy only: an entry being
    // consumed this cycle still reads busy and is not reused until next cycle.
    always_comb begin
        alloc_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!busy[i]) begin
                alloc_idx = 2'(i);
            end
        end
    end

    assign disp_ready = ~(&busy);
    assign accept     = disp_valid & disp_ready;

    // Operand capture at dispatch, with same-cycle CDB bypass. A source that
    // is still pending stores value 0 until its wakeup.
    always_comb begin
        cap1_rdy = disp_src1_rdy | (cdb_valid & (cdb_tag == disp_src1_tag));
        cap2_rdy = disp_src2_rdy | (cdb_valid & (cdb_tag == disp_src2_tag));
        cap1_val = disp_src1_rdy ? disp_src1_val : (cap1_rdy ? cdb_value : 32'd0);
        cap2_val = disp_src2_rdy ? disp_src2_val : (cap2_rdy ? cdb_value : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= '0;
            s1_rdy <= '0;
            s2_rdy <= '0;
            for (int i = 0; i < 4; i++) begin
                op_q[i]    <= '0;
                btype_q[i] <= '0;
                rob_q[i]   <= '0;
                s1_tag[i]  <= '0;
                s2_tag[i]  <= '0;
                s1_val[i]  <= '0;
                s2_val[i]  <= '0;
            end
        end else if (flush) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (busy[i]) begin
                    if (cdb_valid && !s1_rdy[i] && (s1_tag[i] == cdb_tag)) begin
                        s1_rdy[i] <= 1'b1;
                        s1_val[i] <= cdb_value;
                    end
                    if (cdb_valid && !s2_rdy[i] && (s2_tag[i] == cdb_tag)) begin
                        s2_rdy[i] <= 1'b1;
                        s2_val[i] <= cdb_value;
                    end
                    if (consumed_bus[i]) begin
                        busy[i] <= 1'b0;
                    end
                end else if (accept && (alloc_idx == 2'(i))) begin
                    // Consume on a free entry is ignored, so allocation wins here.
                    busy[i]    <= 1'b1;
                    op_q[i]    <= disp_ALU_op;
                    btype_q[i] <= disp_branch_type;
                    rob_q[i]   <= disp_ROB_entry;
                    s1_rdy[i]  <= cap1_rdy;
                    s2_rdy[i]  <= cap2_rdy;
                    s1_tag[i]  <= disp_src1_tag;
                    s2_tag[i]  <= disp_src2_tag;
                    s1_val[i]  <= cap1_val;
                    s2_val[i]  <= cap2_val;
                end
            end
        end
    end

    // consumed_bus masks valid_operands combinationally so an entry cannot be
    // issued a second time in the cycle before its busy bit clears.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            outs[i] = '0;
            if (busy[i]) begin
                outs[i].valid_operands = s1_rdy[i] & s2_rdy[i] & ~consumed_bus[i];
                outs[i].ALU_op         = op_q[i];
                outs[i].ROB_entry      = rob_q[i];
                outs[i].branch_type    = btype_q[i];
                outs[i].rs1            = s1_val[i];
                outs[i].rs2            = s2_val[i];
            end
        end
    end

    assign rs0_data = outs[0];
    assign rs1_data = outs[1];
    assign rs2_data = outs[2];
    assign rs3_data = outs[3];

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - self-checking bench for reservation_station
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [2:0]  disp_ALU_op = '0;
    logic [1:0]  disp_branch_type = '0;
    logic [3:0]  disp_ROB_entry = '0;
    logic        disp_src1_rdy = 1'b0;
    logic        disp_src2_rdy = 1'b0;
    logic [3:0]  disp_src1_tag = '0;
    logic [3:0]  disp_src2_tag = '0;
    logic [31:0] disp_src1_val = '0;
    logic [31:0] disp_src2_val = '0;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_tag = '0;
    logic [31:0] cdb_value = '0;
    logic [3:0]  consumed_bus = '0;
    rs_out_t     rs0_data, rs1_data, rs2_data, rs3_data;
    rs_out_t     dut_out [4];

    assign dut_out[0] = rs0_data;
    assign dut_out[1] = rs1_data;
    assign dut_out[2] = rs2_data;
    assign dut_out[3] = rs3_data;

    reservation_station dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_ALU_op(disp_ALU_op), .disp_branch_type(disp_branch_type),
        .disp_ROB_entry(disp_ROB_entry),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .consumed_bus(consumed_bus),
        .rs0_data(rs0_data), .rs1_data(rs1_data), .rs2_data(rs2_data), .rs3_data(rs3_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one record per slot, updated once per clock edge.
    bit          m_busy [4];
    logic [2:0]  m_op   [4];
    logic [1:0]  m_bt   [4];
    logic [3:0]  m_rob  [4];
    bit          m_r1   [4];
    bit          m_r2   [4];
    logic [3:0]  m_t1   [4];
    logic [3:0]  m_t2   [4];
    logic [31:0] m_v1   [4];
    logic [31:0] m_v2   [4];

    function automatic int first_free();
        for (int i = 0; i < 4; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic bit exp_ready();
        return first_free() >= 0;
    endfunction

    function automatic rs_out_t exp_out(input int i);
        rs_out_t r;
        r = '0;
        if (m_busy[i]) begin
            r.valid_operands = m_r1[i] && m_r2[i] && !consumed_bus[i];
            r.ALU_op = m_op[i];
            r.ROB_entry = m_rob[i];
            r.branch_type = m_bt[i];
            r.rs1 = m_v1[i];
            r.rs2 = m_v2[i];
        end
        return r;
    endfunction

    task automatic model_step();
        int f;
        f = first_free();
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_busy[i] = 0; m_op[i] = 0; m_bt[i] = 0; m_rob[i] = 0;
                m_r1[i] = 0; m_r2[i] = 0; m_t1[i] = 0; m_t2[i] = 0; m_v1[i] = 0; m_v2[i] = 0;
            end
        end else if (flush) begin
            for (int i = 0; i < 4; i++) m_busy[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m_busy[i]) begin
                    if (cdb_valid && !m_r1[i] && m_t1[i] == cdb_tag) begin m_r1[i] = 1; m_v1[i] = cdb_value; end
                    if (cdb_valid && !m_r2[i] && m_t2[i] == cdb_tag) begin m_r2[i] = 1; m_v2[i] = cdb_value; end
                    if (consumed_bus[i]) m_busy[i] = 0;
                end
            end
            if (disp_valid && f >= 0) begin
                m_busy[f] = 1; m_op[f] = disp_ALU_op; m_bt[f] = disp_branch_type; m_rob[f] = disp_ROB_entry;
                m_t1[f] = disp_src1_tag; m_t2[f] = disp_src2_tag;
                if (disp_src1_rdy) begin m_r1[f] = 1; m_v1[f] = disp_src1_val; end
                else if (cdb_valid && cdb_tag == disp_src1_tag) begin m_r1[f] = 1; m_v1[f] = cdb_value; end
                else begin m_r1[f] = 0; m_v1[f] = 0; end
                if (disp_src2_rdy) begin m_r2[f] = 1; m_v2[f] = disp_src2_val; end
                else if (cdb_valid && cdb_tag == disp_src2_tag) begin m_r2[f] = 1; m_v2[f] = cdb_value; end
                else begin m_r2[f] = 0; m_v2[f] = 0; end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; disp_valid = 0; cdb_valid = 0; consumed_bus = '0;
        disp_src1_rdy = 0; disp_src2_rdy = 0;
    endtask

    task automatic dispatch(input logic [2:0] op, input logic [1:0] bt, input logic [3:0] rob,
                            input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                            input logic r2, input logic [3:0] t2, input logic [31:0] v2);
        disp_valid = 1; disp_ALU_op = op; disp_branch_type = bt; disp_ROB_entry = rob;
        disp_src1_rdy = r1; disp_src1_tag = t1; disp_src1_val = v1;
        disp_src2_rdy = r2; disp_src2_tag = t2; disp_src2_val = v2;
    endtask

    task automatic test_reset();
        reset = 1; idle(); tick(); tick(); reset = 0; #1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (dut_out[i] !== '0) begin n_fail++; $display("FAIL reset rs%0d got %h exp 0", i, dut_out[i]); end
        end
        n_tests++;
        if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset disp_ready got %b exp 1", disp_ready); end
    endtask

    task automatic test_basic();
        dispatch(3'b000, 2'd0, 4'd3, 1, 4'd0, 32'd5, 1, 4'd0, 32'd7);
        tick(); idle(); #1;
        n_tests++;
        if (rs0_data.valid_operands !== 1'b1 || rs0_data.rs1 !== 32'd5 || rs0_data.rs2 !== 32'd7 || rs0_data.ROB_entry !== 4'd3) begin
            n_fail++; $display("FAIL basic rs0 got %h exp valid=1 rs1=5 rs2=7 rob=3", rs0_data);
        end
        consumed_bus = 4'b0001; #1;
        n_tests++;
        if (rs0_data.valid_operands !== 1'b0) begin n_fail++; $display("FAIL basic_mask valid got %b exp 0", rs0_data.valid_operands); end
        tick(); idle(); #1;
        n_tests++;
        if (rs0_data !== exp_out(0) || disp_ready !== 1'b1) begin n_fail++; $display("FAIL basic_free rs0 got %h exp %h", rs0_data, exp_out(0)); end
    endtask

    task automatic test_wakeup();
        dispatch(3'b010, 2'd1, 4'd6, 1, 4'd0, 32'd1, 0, 4'd9, 32'd0);
        tick(); idle();
        for (int k = 0; k < 2; k++) begin
            #1; n_tests++;
            if (rs0_data.valid_operands !== 1'b0) begin n_fail++; $display("FAIL wakeup_wait%0d valid got %b exp 0", k, rs0_data.valid_operands); end
            if (k == 0) tick();
        end
        cdb_valid = 1; cdb_tag = 4'd9; cdb_value = 32'hDEADBEEF; #1;
        n_tests++;
        if (rs0_data.valid_operands !== 1'b0) begin n_fail++; $display("FAIL wakeup_bcast valid got %b exp 0", rs0_data.valid_operands); end
        tick(); idle(); #1;
        n_tests++;
        if (rs0_data.valid_operands !== 1'b1 || rs0_data.rs2 !== 32'hDEADBEEF || rs0_data !== exp_out(0)) begin
            n_fail++; $display("FAIL wakeup_done rs0 got %h exp %h", rs0_data, exp_out(0));
        end
        consumed_bus = 4'b0001; tick(); idle();
    endtask

    task automatic test_bypass();
        dispatch(3'b001, 2'd2, 4'd4, 0, 4'd4, 32'd0, 1, 4'd0, 32'd2);
        cdb_valid = 1; cdb_tag = 4'd4; cdb_value = 32'h11;
        tick(); idle(); #1;
        n_tests++;
        if (rs0_data.valid_operands !== 1'b1 || rs0_data.rs1 !== 32'h11 || rs0_data !== exp_out(0)) begin
            n_fail++; $display("FAIL bypass rs0 got %h exp valid=1 rs1=11", rs0_data);
        end
        consumed_bus = 4'b0001; tick(); idle();
    endtask

    task automatic test_full_consume();
        for (int k = 0; k < 4; k++) begin
            dispatch(3'(k), 2'(k), 4'(8 + k), 1, 4'd0, 32'(100 + k), 1, 4'd0, 32'(200 + k));
            tick();
        end
        idle(); #1;
        n_tests++;
        if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full disp_ready got %b exp 0", disp_ready); end
        dispatch(3'd7, 2'd3, 4'd15, 1, 4'd0, 32'd9, 1, 4'd0, 32'd9);
        tick(); idle(); #1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (dut_out[i] !== exp_out(i) || dut_out[i].ROB_entry !== 4'(8 + i)) begin
                n_fail++; $display("FAIL full_ignore rs%0d got %h exp %h", i, dut_out[i], exp_out(i));
            end
        end
        consumed_bus = 4'b0100; #1;
        n_tests++;
        if (rs2_data.valid_operands !== 1'b0 || rs0_data.valid_operands !== 1'b1) begin
            n_fail++; $display("FAIL full_mask rs2 valid got %b exp 0 rs0 valid got %b exp 1", rs2_data.valid_operands, rs0_data.valid_operands);
        end
        tick(); idle(); #1;
        n_tests++;
        if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL full_reopen disp_ready got %b exp 1", disp_ready); end
        dispatch(3'd5, 2'd1, 4'd14, 1, 4'd0, 32'd55, 1, 4'd0, 32'd66);
        tick(); idle(); #1;
        n_tests++;
        if (rs2_data.ROB_entry !== 4'd14 || rs2_data.rs1 !== 32'd55 || disp_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_realloc rs2 got %h ready %b exp rob=e ready=0", rs2_data, disp_ready);
        end
    endtask

    task automatic test_consume_mask();
        consumed_bus = 4'b0001; #1;
        n_tests++;
        if (rs0_data.valid_operands !== 1'b0 || rs1_data.valid_operands !== 1'b1) begin
            n_fail++; $display("FAIL cmask_now rs0 valid got %b exp 0 rs1 valid got %b exp 1", rs0_data.valid_operands, rs1_data.valid_operands);
        end
        tick(); idle();
        for (int k = 0; k < 2; k++) begin
            #1; n_tests++;
            if (rs0_data.valid_operands !== 1'b0 || rs1_data.valid_operands !== 1'b1) begin
                n_fail++; $display("FAIL cmask_after%0d rs0 valid got %b exp 0 rs1 valid got %b exp 1", k, rs0_data.valid_operands, rs1_data.valid_operands);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        // Entries 1..3 are still busy here.
        dispatch(3'd3, 2'd0, 4'd0, 1, 4'd0, 32'd1, 1, 4'd0, 32'd2);
        flush = 1;
        tick(); idle(); #1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (dut_out[i] !== '0) begin n_fail++; $display("FAIL flush rs%0d got %h exp 0", i, dut_out[i]); end
        end
        n_tests++;
        if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL flush disp_ready got %b exp 1", disp_ready); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 29) == 0);
            disp_valid = ($urandom_range(0, 1) == 1);
            disp_ALU_op = 3'($urandom); disp_branch_type = 2'($urandom); disp_ROB_entry = 4'($urandom);
            disp_src1_rdy = ($urandom_range(0, 2) == 0); disp_src2_rdy = ($urandom_range(0, 2) == 0);
            disp_src1_tag = 4'($urandom_range(0, 3)); disp_src2_tag = 4'($urandom_range(0, 3));
            disp_src1_val = $urandom; disp_src2_val = $urandom;
            cdb_valid = ($urandom_range(0, 1) == 1);
            cdb_tag = 4'($urandom_range(0, 3)); cdb_value = $urandom;
            consumed_bus = ($urandom_range(0, 2) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
            #1;
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (dut_out[i] !== exp_out(i)) begin n_fail++; $display("FAIL random c%0d rs%0d got %h exp %h", c, i, dut_out[i], exp_out(i)); end
            end
            n_tests++;
            if (disp_ready !== exp_ready()) begin n_fail++; $display("FAIL random c%0d disp_ready got %b exp %b", c, disp_ready, exp_ready()); end
            tick();
        end
        reset = 0; idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_bypass();
        test_full_consume();
        test_consume_mask();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
# reservation_station

Four-entry unified reservation station in the Execute stage, directly upstream of the functional-unit scheduler. It accepts one dispatched instruction per cycle and captures operand values from the dispatch bus or the common data bus (CDB). It presents each entry to the scheduler as an `rs_out_t` record and frees entries on the scheduler's one-hot `consumed_bus`. Entry `i` drives `rs<i>_data`; the scheduler's fixed priority (entry 0 highest) therefore determines issue order.

## Interface
Parameters:
- none; depth fixed at 4 entries, tag width 4 (ROB index), data width 32.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  branch-mispredict squash; invalidates all entries.
- `disp_valid`  in  1  dispatch request this cycle.
- `disp_ready`  out  1  at least one entry free; dispatch accepted only when `disp_valid & disp_ready`.
- `disp_ALU_op`  in  3  operation class, stored verbatim.
- `disp_branch_type`  in  2  stored verbatim.
- `disp_ROB_entry`  in  4  destination ROB index.
- `disp_src1_rdy`, `disp_src2_rdy`  in  1 each  operand value already available.
- `disp_src1_tag`, `disp_src2_tag`  in  4 each  producing ROB index when not ready.
- `disp_src1_val`, `disp_src2_val`  in  32 each  operand value when ready.
- `cdb_valid`  in  1  result broadcast this cycle.
- `cdb_tag`  in  4  ROB index of the broadcast result.
- `cdb_value`  in  32  broadcast result.
- `consumed_bus`  in  4  one-hot, from the scheduler; bit `i` frees entry `i`.
- `rs0_data` … `rs3_data`  out  `rs_out_t` each  fields: `valid_operands`, `ALU_op[2:0]`, `ROB_entry[3:0]`, `branch_type[1:0]`, `rs1[31:0]`, `rs2[31:0]`.

## Operation
- Per-entry state: `busy`, `op`, `btype`, `rob`, and per source `rdy`, `tag`, `val`.
- Allocation: the lowest-index entry with `busy=0` is allocated, judged on registered `busy`.
  - An entry freed by `consumed_bus` in the same cycle is not reusable until the next cycle.
- Dispatch capture: for each source, if `disp_srcN_rdy=1`, store `disp_srcN_val` with `rdy=1`.
  - Otherwise, if `cdb_valid` is high and `cdb_tag == disp_srcN_tag`, store `cdb_value` with `rdy=1` (same-cycle bypass).
  - Otherwise store the tag with `rdy=0`.
- CDB wakeup: each busy entry with a non-ready source whose tag equals `cdb_tag`, while `cdb_valid` is high, latches `cdb_value` and sets `rdy=1`.
  - Both sources of one entry can wake on the same broadcast.
- `valid_operands[i] = busy[i] & src1.rdy[i] & src2.rdy[i] & ~consumed_bus[i]`.
  - The `consumed_bus` term is combinational.
  - It masks the entry during the cycle the scheduler reports consumption, which prevents a second issue before the clear.
- Free: `consumed_bus[i]=1` clears `busy[i]` at the clock edge.
  - If `consumed_bus[i]` is asserted for a non-busy entry, it is ignored.
- Output fields when `busy=0`: all zero. When `busy=1`: the stored values.
- `flush`: clears all `busy` bits at the edge and overrides dispatch, CDB and consumed in that cycle. `disp_ready` is unaffected combinationally during the flush cycle.
- `reset`: same effect as `flush`, and also zeroes all stored fields.
- `disp_ready = ~(&busy)`, derived from registered state only.

## Timing
- Reset values:
  - all `rsN_data` fields 0;
  - `disp_ready=1`.
- Dispatch to visibility:
  - An instruction accepted in cycle t with both operands ready shows `valid_operands=1` in cycle t+1.
  - If the second operand arrives on the CDB in cycle t+k, the entry is visible in t+k+1.
- Issue and consume sequence:
  - The scheduler issues entry i in cycle t.
  - `consumed_bus[i]=1` arrives in t+1, and `valid_operands[i]` drops combinationally in t+1.
  - `busy[i]=0` from t+2, and the entry is allocatable from t+2.
- Full condition: with 4 busy entries, `disp_ready=0`, and `disp_valid` is ignored.
- Full plus consume: entry i is consumed in cycle t. `disp_ready` rises in t+1, and the next dispatch lands in entry i.
- Simultaneous dispatch and flush: the dispatch is dropped, and all entries are empty in the next cycle.
- Tag 0 is a valid ROB index; there is no reserved tag value.

## Test plan
- Reset, then dispatch `ALU_op=000`, `ROB=3`, src1=5, src2=7, both ready -> cycle+1: `rs0_data.valid_operands=1`, `rs1=5`, `rs2=7`, `ROB_entry=3`.
- Dispatch src2 not ready with tag 9, then `cdb_valid` with tag 9 and value `0xDEADBEEF` two cycles later -> `valid_operands` stays 0 until the cycle after the broadcast, then 1 with `rs2=0xDEADBEEF`.
- Dispatch with src1 tag 4 in the same cycle as a CDB broadcast of tag 4 and value `0x11` -> entry stores `rs1=0x11` and is valid next cycle (bypass).
- Fill all 4 entries -> `disp_ready=0`. Then pulse `consumed_bus=0100` -> `rs2_data.valid_operands` is 0 in that cycle, `disp_ready=1` next cycle, and the next dispatch allocates entry 2.
- Hold entry 0 ready and apply `consumed_bus=0001` for one cycle -> entry 0 never shows `valid_operands=1` after the consume cycle, and entry 1 (if ready) remains visible.
- With 3 entries busy, assert `flush` together with `disp_valid` -> next cycle all `valid_operands=0`, all fields 0, `disp_ready=1`.
